// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared address map, slave selects, FSM encoding and timeout limit
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DM_LO     = 32'h0000_0000;
  localparam logic [31:0] DM_HI     = 32'h0000_2FFF;
  localparam logic [31:0] TIMER_LO  = 32'h0000_7F00;
  localparam logic [31:0] TIMER_HI  = 32'h0000_7F0B;
  localparam logic [31:0] UART_LO   = 32'h0000_7F10;
  localparam logic [31:0] UART_HI   = 32'h0000_7F2B;
  localparam logic [31:0] SWITCH_LO = 32'h0000_7F2C;
  localparam logic [31:0] SWITCH_HI = 32'h0000_7F33;
  localparam logic [31:0] LED_LO    = 32'h0000_7F34;
  localparam logic [31:0] LED_HI    = 32'h0000_7F37;
  localparam logic [31:0] DIG_LO    = 32'h0000_7F38;
  localparam logic [31:0] DIG_HI    = 32'h0000_7F3F;
  localparam logic [31:0] BUTTON_LO = 32'h0000_7F40;
  localparam logic [31:0] BUTTON_HI = 32'h0000_7F43;

  // s_sel bit order is {BUTTON, DIG, LED, SWITCH, UART, TIMER, DM}
  localparam logic [6:0] SEL_NONE   = 7'b000_0000;
  localparam logic [6:0] SEL_DM     = 7'b000_0001;
  localparam logic [6:0] SEL_TIMER  = 7'b000_0010;
  localparam logic [6:0] SEL_UART   = 7'b000_0100;
  localparam logic [6:0] SEL_SWITCH = 7'b000_1000;
  localparam logic [6:0] SEL_LED    = 7'b001_0000;
  localparam logic [6:0] SEL_DIG    = 7'b010_0000;
  localparam logic [6:0] SEL_BUTTON = 7'b100_0000;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational slave decode and access legality check
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  output logic [6:0]  sel_o,
  output logic        err_o
);

  logic align_ok;

  always_comb begin
    sel_o = SEL_NONE;
    if (in_range(addr_i, DM_LO, DM_HI))               sel_o = SEL_DM;
    else if (in_range(addr_i, TIMER_LO, TIMER_HI))    sel_o = SEL_TIMER;
    else if (in_range(addr_i, UART_LO, UART_HI))      sel_o = SEL_UART;
    else if (in_range(addr_i, SWITCH_LO, SWITCH_HI))  sel_o = SEL_SWITCH;
    else if (in_range(addr_i, LED_LO, LED_HI))        sel_o = SEL_LED;
    else if (in_range(addr_i, DIG_LO, DIG_HI))        sel_o = SEL_DIG;
    else if (in_range(addr_i, BUTTON_LO, BUTTON_HI))  sel_o = SEL_BUTTON;
  end

  // Only naturally aligned byte/half/word lane patterns are legal; be=0000 falls to default.
  always_comb begin
    align_ok = 1'b0;
    case (be_i)
      4'b0001: align_ok = (addr_i[1:0] == 2'd0);
      4'b0010: align_ok = (addr_i[1:0] == 2'd1);
      4'b0100: align_ok = (addr_i[1:0] == 2'd2);
      4'b1000: align_ok = (addr_i[1:0] == 2'd3);
      4'b0011: align_ok = (addr_i[1:0] == 2'd0);
      4'b1100: align_ok = (addr_i[1:0] == 2'd2);
      4'b1111: align_ok = (addr_i[1:0] == 2'd0);
      default: align_ok = 1'b0;
    endcase
  end

  assign err_o = (sel_o == SEL_NONE) || !align_ok ||
                 (we_i && (sel_o != SEL_DM) && (be_i != 4'b1111));

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter; BUS_TIMEOUT_EN adds a BUSY timeout
module bus_arbiter
  import bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [6:0]  s_sel,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_be,
  output logic        s_we,
  input  logic [31:0] s_rdata,
  input  logic        s_ready
);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;      // 1 = m1 owns the current access
  logic        last_q, last_d;    // 1 = m1 won the previous grant
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        s_valid_q, s_valid_d;
  logic [6:0]  s_sel_q, s_sel_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_be_q, s_be_d;
  logic        s_we_q, s_we_d;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
`endif

  logic        pick_m1;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic        req_we;
  logic [6:0]  dec_sel;
  logic        dec_err;

  // On a tie the master that did not win last time gets the bus.
  assign pick_m1  = m1_req && (!m0_req || !last_q);
  assign req_addr = pick_m1 ? m1_addr : m0_addr;
  assign req_be   = pick_m1 ? m1_be   : m0_be;
  assign req_we   = pick_m1 ? m1_we   : m0_we;

  bus_addr_decode u_decode (
    .addr_i (req_addr),
    .be_i   (req_be),
    .we_i   (req_we),
    .sel_o  (dec_sel),
    .err_o  (dec_err)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    err_d     = err_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    s_valid_d = s_valid_q;
    s_sel_d   = s_sel_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    s_we_d    = s_we_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d     = pick_m1;
          last_d    = pick_m1;
          s_addr_d  = req_addr;
          s_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          s_be_d    = req_be;
          s_we_d    = req_we;
          err_d     = dec_err;
          rdata_d   = '0;
          if (dec_err) begin
            ack_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            s_valid_d = 1'b1;
            s_sel_d   = dec_sel;
            state_d   = ST_BUSY;
`ifdef BUS_TIMEOUT_EN
            tmo_d     = '0;
`endif
          end
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          rdata_d   = s_we_q ? 32'd0 : s_rdata;
          s_valid_d = 1'b0;
          s_sel_d   = SEL_NONE;
          ack_d     = 1'b1;
          state_d   = ST_RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_LIMIT - 8'd1) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          s_valid_d = 1'b0;
          s_sel_d   = SEL_NONE;
          ack_d     = 1'b1;
          state_d   = ST_RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      s_valid_q <= 1'b0;
      s_sel_q   <= SEL_NONE;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      s_we_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      s_valid_q <= s_valid_d;
      s_sel_q   <= s_sel_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
      s_we_q    <= s_we_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign m0_ack   = ack_q && !gnt_q;
  assign m1_ack   = ack_q && gnt_q;
  assign m0_err   = m0_ack && err_q;
  assign m1_err   = m1_ack && err_q;
  assign m0_rdata = m0_ack ? rdata_q : 32'd0;
  assign m1_rdata = m1_ack ? rdata_q : 32'd0;
  assign s_valid  = s_valid_q;
  assign s_sel    = s_sel_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_be     = s_be_q;
  assign s_we     = s_we_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter (BUS_TIMEOUT_EN selects the timeout case)
module tb_bus_arbiter;

  localparam logic [6:0] E_NONE   = 7'b000_0000;
  localparam logic [6:0] E_DM     = 7'b000_0001;
  localparam logic [6:0] E_TIMER  = 7'b000_0010;
  localparam logic [6:0] E_UART   = 7'b000_0100;
  localparam logic [6:0] E_SWITCH = 7'b000_1000;
  localparam logic [6:0] E_LED    = 7'b001_0000;
  localparam logic [6:0] E_DIG    = 7'b010_0000;
  localparam logic [6:0] E_BUTTON = 7'b100_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_we, s_ready;
  logic [6:0]  s_sel;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
    logic [6:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ready_delay = 0;
  int   busy_cnt = 0;
  logic hold_ready = 1'b0;
  logic [6:0] seen_sel = '0;

  always #5 clk = ~clk;

  bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_we(s_we), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  // Slave returns a data word derived from its address so loads are distinguishable.
  assign s_rdata = s_addr ^ 32'h5A5A_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int m, input logic err, input logic [31:0] rd, input logic [6:0] sel);
    exp_t e;
    e.m = m; e.err = err; e.rdata = rd; e.sel = sel;
    exp_q.push_back(e);
  endtask

  initial begin
    s_ready = 1'b0;
    forever begin
      @(negedge clk);
      s_ready  = (s_valid && !hold_ready && busy_cnt >= ready_delay);
      busy_cnt = s_valid ? busy_cnt + 1 : 0;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) seen_sel = '0;
      else if (s_valid) seen_sel = seen_sel | s_sel;
      if (m0_ack || m1_ack) begin
        chk("single_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {31'd0, m1_ack}, {31'd0, 1'b0} + 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("ack_master", {31'd0, m1_ack}, e.m[31:0]);
          chk("ack_err", {31'd0, m0_err | m1_err}, {31'd0, e.err});
          chk("ack_rdata", m0_rdata | m1_rdata, e.rdata);
          chk("ack_sel", {25'd0, seen_sel}, {25'd0, e.sel});
        end
        seen_sel = '0;
      end
    end
  end

  task automatic set_master(input int m, input logic req, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input logic we);
    if (m == 0) begin
      m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_we = we;
    end else begin
      m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_we = we;
    end
  endtask

  task automatic master_access(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic we, output int lat);
    logic got;
    @(negedge clk);
    set_master(m, 1'b1, addr, wdata, be, we);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = (m == 0) ? m0_ack : m1_ack;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  task automatic wait_ack(input int m, input int bound);
    logic got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ack : m1_ack;
    end
    if (!got) chk("wait_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int lat, lat1, vcnt;

  initial begin
    set_master(0, 1'b0, '0, '0, '0, 1'b0);
    set_master(1, 1'b0, '0, '0, '0, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_s_sel", {25'd0, s_sel}, 32'd0);
    chk("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    reset_n = 1'b1;

    // Minimum-latency DM load
    push_exp(0, 1'b0, 32'h5A5A_0004, E_DM);
    master_access(0, 32'h0000_0004, 32'd0, 4'b1111, 1'b0, lat);
    chk("min_latency", lat, 32'd2);

    // Round robin: tie twice -> m0, m1, m0, m1
    do_reset();
    push_exp(0, 1'b0, 32'h5A5A_0010, E_DM);
    push_exp(1, 1'b0, 32'h5A5A_7F00, E_TIMER);
    fork
      master_access(0, 32'h0000_0010, 32'd0, 4'b1111, 1'b0, lat);
      master_access(1, 32'h0000_7F00, 32'd0, 4'b1111, 1'b0, lat1);
    join
    push_exp(0, 1'b0, 32'h5A5A_7F40, E_BUTTON);
    push_exp(1, 1'b0, 32'h5A5A_7F3C, E_DIG);
    fork
      master_access(0, 32'h0000_7F40, 32'd0, 4'b0001, 1'b0, lat);
      master_access(1, 32'h0000_7F3C, 32'd0, 4'b1111, 1'b0, lat1);
    join

    // Peripheral store width rules, error paths and map boundaries
    push_exp(0, 1'b1, 32'd0, E_NONE);
    master_access(0, 32'h0000_7F34, 32'h0000_00FF, 4'b0011, 1'b1, lat);
    ready_delay = 3;
    push_exp(0, 1'b0, 32'd0, E_LED);
    master_access(0, 32'h0000_7F34, 32'h0000_00FF, 4'b1111, 1'b1, lat);
    ready_delay = 0;
    push_exp(1, 1'b1, 32'd0, E_NONE);
    master_access(1, 32'h0000_5000, 32'd0, 4'b1111, 1'b0, lat);
    push_exp(1, 1'b1, 32'd0, E_NONE);
    master_access(1, 32'h0000_0001, 32'h1234_5678, 4'b0011, 1'b1, lat);
    push_exp(0, 1'b1, 32'd0, E_NONE);
    master_access(0, 32'h0000_0000, 32'd0, 4'b0000, 1'b0, lat);
    push_exp(0, 1'b0, 32'h5A5A_2FFC, E_DM);
    master_access(0, 32'h0000_2FFC, 32'd0, 4'b1111, 1'b0, lat);
    push_exp(0, 1'b1, 32'd0, E_NONE);
    master_access(0, 32'h0000_3000, 32'd0, 4'b1111, 1'b0, lat);
    push_exp(1, 1'b0, 32'h5A5A_7F2B, E_UART);
    master_access(1, 32'h0000_7F2B, 32'd0, 4'b1000, 1'b0, lat);
    push_exp(1, 1'b0, 32'h5A5A_7F2C, E_SWITCH);
    master_access(1, 32'h0000_7F2C, 32'd0, 4'b1111, 1'b0, lat);

    // m0 drops req mid-BUSY, still gets its ack; m1 waits then completes
    push_exp(0, 1'b0, 32'h5A5A_0020, E_DM);
    push_exp(1, 1'b0, 32'h5A5A_7F10, E_UART);
    fork
      begin
        @(negedge clk);
        hold_ready = 1'b1;
        set_master(0, 1'b1, 32'h0000_0020, 32'd0, 4'b1111, 1'b0);
        repeat (3) @(negedge clk);
        m0_req = 1'b0;
        repeat (2) @(negedge clk);
        hold_ready = 1'b0;
        wait_ack(0, 10);
      end
      begin
        repeat (2) @(negedge clk);
        master_access(1, 32'h0000_7F10, 32'd0, 4'b1111, 1'b0, lat1);
      end
    join

    // Slave never ready
    hold_ready = 1'b1;
`ifdef BUS_TIMEOUT_EN
    push_exp(1, 1'b1, 32'd0, E_UART);
    @(negedge clk);
    set_master(1, 1'b1, 32'h0000_7F10, 32'd0, 4'b1111, 1'b0);
    @(negedge clk);
    vcnt = 0;
    for (int i = 0; i < 400 && s_valid; i++) begin
      vcnt++;
      @(negedge clk);
    end
    chk("timeout_cycles", vcnt, 32'd255);
    chk("timeout_ack", {31'd0, m1_ack}, 32'd1);
    m1_req = 1'b0;
    hold_ready = 1'b0;
`else
    push_exp(1, 1'b0, 32'h5A5A_7F10, E_UART);
    @(negedge clk);
    set_master(1, 1'b1, 32'h0000_7F10, 32'd0, 4'b1111, 1'b0);
    repeat (1000) @(negedge clk);
    chk("no_timeout_valid", {31'd0, s_valid}, 32'd1);
    chk("no_timeout_ack", {31'd0, m1_ack}, 32'd0);
    hold_ready = 1'b0;
    wait_ack(1, 10);
    m1_req = 1'b0;
`endif

    // Reset while BUSY aborts the store with no ack
    @(negedge clk);
    hold_ready = 1'b1;
    set_master(0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'b1111, 1'b1);
    vcnt = 0;
    for (int i = 0; i < 10 && !s_valid; i++) begin
      @(negedge clk);
      vcnt++;
    end
    chk("busy_reached", {31'd0, s_valid}, 32'd1);
    reset_n = 1'b0;
    m0_req = 1'b0;
    @(negedge clk);
    chk("rstbusy_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rstbusy_s_sel", {25'd0, s_sel}, 32'd0);
    chk("rstbusy_s_addr", s_addr, 32'd0);
    chk("rstbusy_s_wdata", s_wdata, 32'd0);
    chk("rstbusy_s_be_we", {27'd0, s_be, s_we}, 32'd0);
    chk("rstbusy_ack", {30'd0, m0_ack, m0_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hold_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstbusy_no_ack_after", {31'd0, m0_ack}, 32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; reset_n  in  1  synchronous active-low reset.
REQ-002 SHALL have m0_req / m1_req  in  1  access request (m0 = CPU MEM stage, m1 = debug/DMA), held until ack.
REQ-003 SHALL have m0_addr / m1_addr  in  32  byte address.
REQ-004 SHALL have m0_wdata / m1_wdata  in  32  store data.
REQ-005 SHALL have m0_be / m1_be  in  4  byte enables (0001/0010/0100/1000 byte, 0011/1100 half, 1111 word).
REQ-006 SHALL have m0_we / m1_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have m0_ack / m1_ack, m0_err / m1_err  out  1  one-cycle completion and error pulses.
REQ-008 SHALL have m0_rdata / m1_rdata  out  32  load data, valid while ack.
REQ-009 SHALL have s_valid  out  1  slave access active; s_sel  out  7  one-hot {BUTTON, DIG, LED, SWITCH, UART, TIMER, DM}.
REQ-010 SHALL have s_addr, s_wdata  out  32 and s_be  out  4 (latched copies); s_we  out  1.
REQ-011 SHALL have s_rdata  in  32 and s_ready  in  1  slave completion.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-013 SHALL, in IDLE, grant among asserted requests round-robin, each master winning ties alternately; last_grant resets to m1 so m0 wins first.
REQ-014 SHALL, on grant, latch addr/wdata/be/we and decode s_sel from the map DM 0x0000-0x2FFF, TIMER 0x7F00-0x7F0B, UART 0x7F10-0x7F2B, SWITCH 0x7F2C-0x7F33, LED 0x7F34-0x7F37, DIG 0x7F38-0x7F3F, BUTTON 0x7F40-0x7F43.
REQ-015 SHALL flag an access as erroneous if unmapped, if be=0000, if be does not match addr[1:0] alignment, or if it is a non-DM store with be!=1111; erroneous accesses SHALL go IDLE->RESP without asserting s_valid.
REQ-016 SHALL otherwise go to BUSY, holding s_valid=1 and all s_* outputs stable until s_ready=1, then capture s_rdata and go to RESP.
REQ-017 SHALL, in RESP, pulse the granted master's ack (plus err if erroneous) for exactly one cycle with rdata valid, then return to IDLE; rdata SHALL be 0 on error or store.
REQ-018 SHALL give a minimum latency, with s_ready=1 in the first BUSY cycle, of ack two cycles after the cycle req is sampled in IDLE; no new grant occurs in the RESP cycle.
REQ-019 SHALL complete an in-flight access normally if its req drops mid-BUSY, with ack still pulsed, and the ungranted master SHALL wait without loss.
REQ-020 SHALL never assert s_valid outside BUSY and never drive two s_sel bits at once.

Reset
REQ-021 SHALL, on reset_n=0 at a clk edge, enter IDLE and clear every output (acks, errs, rdata, s_valid, s_sel, s_addr, s_wdata, s_be, s_we) to 0, plus the timeout counter; an access aborted mid-BUSY SHALL NOT be acked.

Configuration
REQ-022 SHALL, with BUS_TIMEOUT_EN defined, count BUSY cycles in an 8-bit counter and, when 255 cycles elapse without s_ready, drop s_valid and go to RESP with err=1.
REQ-023 SHALL, without BUS_TIMEOUT_EN, omit the counter and wait in BUSY indefinitely.

Structure
REQ-024 SHALL place the address-map bounds, the s_sel one-hot encodings, the state encoding and the timeout limit (255) in shared package bus_pkg.
REQ-025 SHALL implement decoding and the error check as combinational sub-module bus_addr_decode (addr, be, we -> sel, err).

Verification
REQ-026 SHALL verify: m0 load addr 0x0004, be 1111, s_ready=1 immediately -> s_sel=DM, ack two cycles after req, m0_rdata=s_rdata.
REQ-027 SHALL verify: m0 and m1 requesting together, then repeatedly -> grants alternate m0, m1, m0, m1.
REQ-028 SHALL verify: m0 store addr 0x7F34 be 0011 -> no s_valid, m0_ack=1 with m0_err=1; store be 1111 -> s_sel=LED, no err.
REQ-029 SHALL verify: m1 access to 0x5000 -> err, s_valid stays 0; store addr 0x0001 be 0011 -> err (misaligned).
REQ-030 SHALL verify: with BUS_TIMEOUT_EN, UART access with s_ready held 0 -> s_valid drops after 255 cycles, ack+err; without the macro, still waiting at 1000 cycles.
REQ-031 SHALL verify: reset_n=0 during BUSY -> next cycle IDLE, all outputs 0, no ack.
